memory_loader: RTL

Sequential write engine for the 8-bit `Memory` block. It accepts a stream of bytes over a valid/ready handshake and writes them to consecutive memory addresses starting at a programmable base. It can optionally read the written region back and compare an 8-bit additive checksum. It is the writer-side counterpart to the sequential address-stepping reader, and loads data sets into `Memory` before the ASIP max/min/avg pass runs.

---
 rtl/memory_loader_if.sv | 45 ++++
 rtl/memory_loader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/memory_loader_if.sv
// rtl/memory_loader_if.sv - job control, byte stream and memory port bundle for memory_loader
//
// Groups every non-clock/reset signal of the loader.
//   slave  : the loader's view (job inputs, Load_* stream in, Mem_* port out, status out)
//   master : the controlling side (drives jobs and stream, models the memory read data)
// Job control : Start, Base_address, Count, Verify_en
// Byte stream : Load_data, Load_valid, Load_ready
// Memory port : Mem_address, Mem_data_in, Mem_write, Mem_data_out
// Status      : Busy, Done, Checksum, Verify_error

interface memory_loader_if;
    logic       Start;
    logic [7:0] Base_address;
    logic [7:0] Count;
    logic       Verify_en;
    logic [7:0] Load_data;
    logic       Load_valid;
    logic       Load_ready;
    logic [7:0] Mem_address;
    logic [7:0] Mem_data_in;
    logic       Mem_write;
    logic [7:0] Mem_data_out;
    logic       Busy;
    logic       Done;
    logic [7:0] Checksum;
    logic       Verify_error;

    modport slave (
        input  Start, Base_address, Count, Verify_en,
        input  Load_data, Load_valid,
        output Load_ready,
        output Mem_address, Mem_data_in, Mem_write,
        input  Mem_data_out,
        output Busy, Done, Checksum, Verify_error
    );

    modport master (
        output Start, Base_address, Count, Verify_en,
        output Load_data, Load_valid,
        input  Load_ready,
        input  Mem_address, Mem_data_in, Mem_write,
        output Mem_data_out,
        input  Busy, Done, Checksum, Verify_error
    );
endinterface

// File: rtl/memory_loader.sv
// rtl/memory_loader.sv - sequential byte-stream write engine with optional checksum read-back
//
// Writes Count streamed bytes to Base_address, Base_address+1, ... (wrapping modulo 256),
// summing them into Checksum. With Verify_en it then reads the region back and flags
// Verify_error when the read-back sum differs.
// Ports:
//   CLK   : single clock, rising edge
//   Reset : synchronous, active high
//   bus   : memory_loader_if.slave (job control, byte stream, memory port, status)

module memory_loader (
    input  logic                  CLK,
    input  logic                  Reset,
    memory_loader_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state, next_state;

    logic [7:0] base_q;
    logic [7:0] count_q;
    logic [7:0] remaining_q;
    logic [7:0] wr_ptr_q;
    logic [7:0] vidx_q;
    logic [7:0] rb_sum_q;
    logic       verify_en_q;
    logic       issue_q;        // Mem_address holds a read address this cycle
    logic       rd_valid_q;     // Mem_data_out holds that read's data this cycle

    logic       start_accept;
    logic       load_ready;
    logic       accept;
    logic [7:0] rb_sum_final;

    assign load_ready     = (state == WRITE) && (remaining_q != 8'd0);
    assign bus.Load_ready = load_ready;
    assign accept         = bus.Load_valid && load_ready;

    // The last read byte lands during the DONE state, so the compare uses the sum
    // including whatever byte is arriving this cycle.
    assign rb_sum_final   = rb_sum_q + (rd_valid_q ? bus.Mem_data_out : 8'h00);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                // Busy stays high through the Done cycle, when the FSM is already back in IDLE.
                start_accept = bus.Start && !bus.Busy;
                if (start_accept) begin
                    next_state = (bus.Count != 8'd0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (accept && (remaining_q == 8'd1)) begin
                    next_state = verify_en_q ? VERIFY : DONE;
                end
            end
            VERIFY: begin
                // Count address cycles plus one trailing cycle for the last read to return.
                if (vidx_q == count_q) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            base_q           <= 8'h00;
            count_q          <= 8'h00;
            remaining_q      <= 8'h00;
            wr_ptr_q         <= 8'h00;
            vidx_q           <= 8'h00;
            rb_sum_q         <= 8'h00;
            verify_en_q      <= 1'b0;
            issue_q          <= 1'b0;
            rd_valid_q       <= 1'b0;
            bus.Mem_address  <= 8'h00;
            bus.Mem_data_in  <= 8'h00;
            bus.Mem_write    <= 1'b0;
            bus.Busy         <= 1'b0;
            bus.Done         <= 1'b0;
            bus.Checksum     <= 8'h00;
            bus.Verify_error <= 1'b0;
        end else begin
            bus.Mem_write <= accept;
            bus.Done      <= (state == DONE);
            bus.Busy      <= (next_state != IDLE) || (state == DONE);
            issue_q       <= 1'b0;
            rd_valid_q    <= issue_q;
            rb_sum_q      <= rb_sum_final;

            if (start_accept) begin
                base_q           <= bus.Base_address;
                count_q          <= bus.Count;
                verify_en_q      <= bus.Verify_en;
                remaining_q      <= bus.Count;
                wr_ptr_q         <= bus.Base_address;
                vidx_q           <= 8'h00;
                rb_sum_q         <= 8'h00;
                bus.Checksum     <= 8'h00;
                bus.Verify_error <= 1'b0;
            end

            if (accept) begin
                bus.Mem_address <= wr_ptr_q;
                bus.Mem_data_in <= bus.Load_data;
                bus.Checksum    <= bus.Checksum + bus.Load_data;
                wr_ptr_q        <= wr_ptr_q + 8'd1;
                remaining_q     <= remaining_q - 8'd1;
            end

            if ((state == VERIFY) && (vidx_q != count_q)) begin
                bus.Mem_address <= base_q + vidx_q;
                issue_q         <= 1'b1;
                vidx_q          <= vidx_q + 8'd1;
            end

            if ((state == DONE) && verify_en_q) begin
                bus.Verify_error <= (rb_sum_final != bus.Checksum);
            end
        end
    end

endmodule
